alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared 8-bit i8080 ALU. It steps register-class
// arithmetic/logic opcodes and DAD through IDLE/FETCH/EXEC/WB, and owns the flags register.
module alu_sequencer #(
    parameter int XLEN = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [7:0]      opcode,
    input  logic [XLEN-1:0] imm,
    input  logic [15:0]     sp,
    output logic            op_done,
    output logic            op_illegal,
    output logic [2:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] alu_op_a,
    output logic [XLEN-1:0] alu_op_b,
    output logic [4:0]      alu_control,
    output logic [XLEN-1:0] alu_flags_in,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] alu_flags_out,
    output logic [XLEN-1:0] flags,
    input  logic            flags_we,
    input  logic [XLEN-1:0] flags_wdata
);

    localparam logic [XLEN-1:0] FLAGS_SET = XLEN'(8'h02);
    localparam logic [XLEN-1:0] FLAGS_CLR = XLEN'(8'h28);
    localparam logic [2:0]      REG_H     = 3'd4;
    localparam logic [2:0]      REG_L     = 3'd5;
    localparam logic [2:0]      REG_A     = 3'd7;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t          state;
    logic            phase;
    logic [7:0]      op_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] opa_q;
    logic [XLEN-1:0] opb_hold;
    logic [XLEN-1:0] fl_q;
    logic            carry_q;

    logic            cls_alu_r, cls_alu_i, cls_incdec, cls_unary, cls_dad;
    logic            wr_suppress;
    logic [4:0]      ctl;
    logic [2:0]      dest;
    logic [XLEN-1:0] opb_sel;

    function automatic logic legal_op(input logic [7:0] op);
        logic alu_r, alu_i, incdec, unary, dad;
        alu_r  = (op[7:6] == 2'b10) && (op[2:0] != 3'd6);
        alu_i  = (op[7:6] == 2'b11) && (op[2:0] == 3'b110);
        incdec = (op[7:6] == 2'b00) && (op[2:1] == 2'b10) && (op[5:3] != 3'd6);
        unary  = (op[7:6] == 2'b00) && (op[2:0] == 3'b111);
        dad    = (op[7:6] == 2'b00) && (op[3:0] == 4'b1001);
        return alu_r | alu_i | incdec | unary | dad;
    endfunction

    function automatic logic [XLEN-1:0] fix_flags(input logic [XLEN-1:0] v);
        return (v & ~FLAGS_CLR) | FLAGS_SET;
    endfunction

    always_comb begin
        cls_alu_r   = (op_q[7:6] == 2'b10);
        cls_alu_i   = (op_q[7:6] == 2'b11) && (op_q[2:0] == 3'b110);
        cls_incdec  = (op_q[7:6] == 2'b00) && (op_q[2:1] == 2'b10);
        cls_unary   = (op_q[7:6] == 2'b00) && (op_q[2:0] == 3'b111);
        cls_dad     = (op_q[7:6] == 2'b00) && (op_q[3:0] == 4'b1001);
        // CMP compares only; STC/CMC touch the carry only
        wr_suppress = ((cls_alu_r | cls_alu_i) && (op_q[5:3] == 3'b111)) ||
                      (cls_unary && (op_q[5:4] == 2'b11));

        ctl  = '0;
        dest = REG_A;
        if (cls_alu_r || cls_alu_i) begin
            ctl = {2'b00, op_q[5:3]};
        end else if (cls_incdec) begin
            ctl  = {4'b1000, op_q[0]};
            dest = op_q[5:3];
        end else if (cls_unary) begin
            ctl = {2'b01, op_q[5:3]};
        end else if (cls_dad) begin
            ctl  = {4'b1100, phase};
            dest = phase ? REG_H : REG_L;
        end

        opb_sel = opa_q;
        if (cls_alu_r) begin
            opb_sel = rf_rdata;
        end else if (cls_alu_i) begin
            opb_sel = imm_q;
        end else if (cls_dad) begin
            if (op_q[5:4] == 2'b11)
                opb_sel = phase ? XLEN'(sp[15:8]) : XLEN'(sp[7:0]);
            else
                opb_sel = rf_rdata;
        end

        rf_raddr = REG_A;
        if (state == FETCH) begin
            if (cls_dad)         rf_raddr = phase ? REG_H : REG_L;
            else if (cls_incdec) rf_raddr = op_q[5:3];
        end else if (state == EXEC) begin
            if (cls_alu_r)    rf_raddr = op_q[2:0];
            else if (cls_dad) rf_raddr = {op_q[5:4], ~phase};
        end
    end

    // The register file read is combinational, so operand B and control are driven
    // directly during EXEC; opb_hold keeps operand B stable in the other states.
    assign alu_op_a     = opa_q;
    assign alu_op_b     = (state == EXEC) ? opb_sel : opb_hold;
    assign alu_control  = (state == EXEC) ? ctl : 5'b00000;
    assign alu_flags_in = (state == EXEC && cls_dad && phase) ?
                          {flags[XLEN-1:1], carry_q} : flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= 1'b0;
            op_q       <= '0;
            imm_q      <= '0;
            opa_q      <= '0;
            opb_hold   <= '0;
            fl_q       <= '0;
            carry_q    <= 1'b0;
            flags      <= FLAGS_SET;
            op_ready   <= 1'b1;
            op_done    <= 1'b0;
            op_illegal <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            op_done    <= 1'b0;
            op_illegal <= 1'b0;
            rf_we      <= 1'b0;
            if (flags_we && state != WB)
                flags <= fix_flags(flags_wdata);

            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q       <= opcode;
                        imm_q      <= imm;
                        phase      <= 1'b0;
                        op_ready   <= 1'b0;
                        op_illegal <= !legal_op(opcode);
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!legal_op(op_q)) begin
                        op_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        opa_q <= rf_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rf_wdata <= alu_out;
                    fl_q     <= alu_flags_out;
                    opb_hold <= opb_sel;
                    if (cls_dad && !phase)
                        carry_q <= alu_flags_out[0];
                    rf_we    <= !wr_suppress;
                    rf_waddr <= dest;
                    op_done  <= !(cls_dad && !phase);
                    state    <= WB;
                end
                WB: begin
                    if (cls_dad && !phase) begin
                        phase <= 1'b1;
                        state <= FETCH;
                    end else begin
                        if (cls_dad)
                            flags <= fix_flags({flags[XLEN-1:1], fl_q[0]});
                        else
                            flags <= fix_flags(fl_q);
                        op_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
